// File: rtl/stream_aligner_pkg.sv
// Shared types and helpers for the two-stream skew aligner.
package stream_aligner_pkg;

  typedef enum logic [1:0] {
    ALN_IDLE   = 2'd0,
    ALN_LEAD_A = 2'd1,
    ALN_LEAD_B = 2'd2,
    ALN_LOCKED = 2'd3
  } align_state_e;

  // Signed skew needs room for +/-MAX_SKEW.
  function automatic int unsigned skew_width(input int unsigned max_skew);
    return $clog2(max_skew) + 2;
  endfunction

endpackage

// File: rtl/align_fifo.sv
// Single-clock FIFO with combinational read data; one instance per stream.
module align_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full buffer still accepts a write when a read frees a slot in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/stream_aligner.sv
// Buffers the leading of two valid-only streams, emits aligned pairs and measures the skew.
module stream_aligner
  import stream_aligner_pkg::*;
#(
  parameter int unsigned WIDTH_A  = 32,
  parameter int unsigned WIDTH_B  = 32,
  parameter int unsigned MAX_SKEW = 128
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WIDTH_A-1:0]                a_data,
  input  logic                              a_valid,
  input  logic [WIDTH_B-1:0]                b_data,
  input  logic                              b_valid,
  input  logic                              flush,
  output logic                              valid_out,
  output logic [WIDTH_A-1:0]                a_out,
  output logic [WIDTH_B-1:0]                b_out,
  output logic signed [$clog2(MAX_SKEW)+1:0] skew,
  output logic                              skew_valid,
  output logic                              overflow
);

  localparam int unsigned SKEW_W = skew_width(MAX_SKEW);
  localparam int unsigned CW     = $clog2(MAX_SKEW) + 1;
  localparam logic signed [SKEW_W-1:0] SKEW_ONE = SKEW_W'(1);
  localparam logic signed [SKEW_W-1:0] SKEW_MAX = SKEW_W'(MAX_SKEW);
  localparam logic signed [SKEW_W-1:0] SKEW_MIN = -SKEW_MAX;

  align_state_e              state_q;
  align_state_e              state_d;
  logic signed [SKEW_W-1:0]  skew_d;
  logic [WIDTH_A-1:0]        a_rdata;
  logic [WIDTH_B-1:0]        b_rdata;
  logic [CW-1:0]             a_count;
  logic [CW-1:0]             b_count;
  logic                      a_full;
  logic                      b_full;
  logic                      a_empty;
  logic                      b_empty;
  logic                      a_push;
  logic                      b_push;
  logic                      pop;
  logic                      ovf_set;

  assign a_push = a_valid & ~flush;
  assign b_push = b_valid & ~flush;
  // Pairing is driven by registered occupancy, which gives the fixed two-cycle latency.
  assign pop     = (a_count != '0) & (b_count != '0) & ~flush;
  assign ovf_set = (a_push & a_full & ~pop) | (b_push & b_full & ~pop);

  align_fifo #(.WIDTH(WIDTH_A), .DEPTH(MAX_SKEW)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (a_push),
    .pop   (pop),
    .wdata (a_data),
    .rdata (a_rdata),
    .count (a_count),
    .full  (a_full),
    .empty (a_empty)
  );

  align_fifo #(.WIDTH(WIDTH_B), .DEPTH(MAX_SKEW)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (b_push),
    .pop   (pop),
    .wdata (b_data),
    .rdata (b_rdata),
    .count (b_count),
    .full  (b_full),
    .empty (b_empty)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, a_empty, b_empty};

  // Skew measurement FSM: counts leading-side samples until the other side first appears.
  always_comb begin
    state_d = state_q;
    skew_d  = skew;
    case (state_q)
      ALN_IDLE: begin
        if (a_valid && b_valid) begin
          state_d = ALN_LOCKED;
          skew_d  = '0;
        end else if (a_valid) begin
          state_d = ALN_LEAD_A;
          skew_d  = SKEW_ONE;
        end else if (b_valid) begin
          state_d = ALN_LEAD_B;
          skew_d  = -SKEW_ONE;
        end
      end
      ALN_LEAD_A: begin
        if (b_valid)                           state_d = ALN_LOCKED;
        else if (a_valid && skew != SKEW_MAX)  skew_d  = skew + SKEW_ONE;
      end
      ALN_LEAD_B: begin
        if (a_valid)                           state_d = ALN_LOCKED;
        else if (b_valid && skew != SKEW_MIN)  skew_d  = skew - SKEW_ONE;
      end
      ALN_LOCKED: state_d = ALN_LOCKED;
      default:    state_d = ALN_IDLE;
    endcase
    if (flush) begin
      state_d = ALN_IDLE;
      skew_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ALN_IDLE;
      skew       <= '0;
      skew_valid <= 1'b0;
      overflow   <= 1'b0;
      valid_out  <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
    end else begin
      state_q    <= state_d;
      skew       <= skew_d;
      skew_valid <= (state_d == ALN_LOCKED);
      overflow   <= flush ? 1'b0 : (overflow | ovf_set);
      valid_out  <= pop;
      if (pop) begin
        a_out <= a_rdata;
        b_out <= b_rdata;
      end
    end
  end

endmodule

// File: tb/tb_stream_aligner.sv
// Directed self-checking bench for stream_aligner (default 32/32/128 configuration).
module tb_stream_aligner;

  logic              clk;
  logic              rst_n;
  logic [31:0]       a_data;
  logic              a_valid;
  logic [31:0]       b_data;
  logic              b_valid;
  logic              flush;
  logic              valid_out;
  logic [31:0]       a_out;
  logic [31:0]       b_out;
  logic signed [8:0] skew;
  logic              skew_valid;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  stream_aligner #(.WIDTH_A(32), .WIDTH_B(32), .MAX_SKEW(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .flush      (flush),
    .valid_out  (valid_out),
    .a_out      (a_out),
    .b_out      (b_out),
    .skew       (skew),
    .skew_valid (skew_valid),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of inputs, let the edge capture them, return 1 time unit later.
  task automatic drive(input logic av, input logic [31:0] ad, input logic bv,
                       input logic [31:0] bd, input logic fl);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; flush = fl;
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b want 0", valid_out); end
    checks++; if (a_out !== 32'h0) begin errors++; $display("FAIL reset_a_out got %h want 0", a_out); end
    checks++; if (b_out !== 32'h0) begin errors++; $display("FAIL reset_b_out got %h want 0", b_out); end
    checks++; if (skew !== 9'sd0) begin errors++; $display("FAIL reset_skew got %0d want 0", skew); end
    checks++; if (skew_valid !== 1'b0) begin errors++; $display("FAIL reset_skew_valid got %b want 0", skew_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_aligned_pair(input logic [31:0] av, input logic [31:0] bv);
    drive(1'b1, av, 1'b1, bv, 1'b0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL pair_early_valid got %b want 0", valid_out); end
    checks++; if (skew_valid !== 1'b1) begin errors++; $display("FAIL pair_locked got %b want 1", skew_valid); end
    idle();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL pair_valid got %b want 1", valid_out); end
    checks++; if (a_out !== av) begin errors++; $display("FAIL pair_a_out got %h want %h", a_out, av); end
    checks++; if (b_out !== bv) begin errors++; $display("FAIL pair_b_out got %h want %h", b_out, bv); end
    checks++; if (skew !== 9'sd0) begin errors++; $display("FAIL pair_skew got %0d want 0", skew); end
    idle();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL pair_single_cycle got %b want 0", valid_out); end
    checks++; if (a_out !== av) begin errors++; $display("FAIL pair_hold_a got %h want %h", a_out, av); end
  endtask

  task automatic test_lead_a();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 5; i++) drive(1'b1, 32'(i), 1'b0, 32'h0, 1'b0);
    checks++; if (skew !== 9'sd5) begin errors++; $display("FAIL lead_a_skew got %0d want 5", skew); end
    checks++; if (skew_valid !== 1'b0) begin errors++; $display("FAIL lead_a_unlocked got %b want 0", skew_valid); end
    for (int j = 1; j <= 6; j++) begin
      drive(1'b1, 32'(5 + j), 1'b1, 32'(32'hB0 + j), 1'b0);
      if (j == 1) begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lead_a_latency got %b want 0", valid_out); end
        checks++; if (skew_valid !== 1'b1 || skew !== 9'sd5) begin errors++; $display("FAIL lead_a_lock got sv=%b skew=%0d want sv=1 skew=5", skew_valid, skew); end
      end else begin
        checks++;
        if (valid_out !== 1'b1 || a_out !== 32'(j - 1) || b_out !== 32'(32'hB0 + j - 1)) begin
          errors++;
          $display("FAIL lead_a_pair%0d got v=%b a=%h b=%h want v=1 a=%h b=%h", j, valid_out, a_out, b_out, 32'(j - 1), 32'(32'hB0 + j - 1));
        end
      end
    end
  endtask

  task automatic test_lead_b();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 3; i++) drive(1'b0, 32'h0, 1'b1, 32'(32'hC0 + i), 1'b0);
    checks++; if (skew !== -9'sd3) begin errors++; $display("FAIL lead_b_skew got %0d want -3", skew); end
    for (int j = 1; j <= 6; j++) begin
      drive(1'b1, 32'(32'hA0 + j), 1'b1, 32'(32'hC3 + j), 1'b0);
      if (j == 1) begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lead_b_latency got %b want 0", valid_out); end
      end else begin
        checks++;
        if (valid_out !== 1'b1 || a_out !== 32'(32'hA0 + j - 1) || b_out !== 32'(32'hC0 + j - 1)) begin
          errors++;
          $display("FAIL lead_b_pair%0d got v=%b a=%h b=%h want v=1 a=%h b=%h", j, valid_out, a_out, b_out, 32'(32'hA0 + j - 1), 32'(32'hC0 + j - 1));
        end
      end
    end
    checks++; if (skew !== -9'sd3 || skew_valid !== 1'b1) begin errors++; $display("FAIL lead_b_final got skew=%0d sv=%b want -3 1", skew, skew_valid); end
  endtask

  task automatic test_overflow();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 130; i++) begin
      drive(1'b1, 32'(i), 1'b0, 32'h0, 1'b0);
      if (i == 128) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b want 0", overflow); end
      end
      if (i == 129) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      end
    end
    checks++; if (skew !== 9'sd128) begin errors++; $display("FAIL ovf_skew_sat got %0d want 128", skew); end
    checks++; if (skew_valid !== 1'b0) begin errors++; $display("FAIL ovf_unlocked got %b want 0", skew_valid); end
    drive(1'b0, 32'h0, 1'b1, 32'hD1, 1'b0);
    idle();
    checks++;
    if (valid_out !== 1'b1 || a_out !== 32'd1 || b_out !== 32'hD1) begin
      errors++; $display("FAIL ovf_first_pair got v=%b a=%h b=%h want v=1 a=1 b=d1", valid_out, a_out, b_out);
    end
    checks++; if (overflow !== 1'b1 || skew !== 9'sd128) begin errors++; $display("FAIL ovf_sticky got ovf=%b skew=%0d want 1 128", overflow, skew); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h99, 1'b1, 32'hD2, 1'b0);
    drive(1'b1, 32'h77, 1'b1, 32'h78, 1'b1);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", valid_out); end
    checks++; if (skew_valid !== 1'b0) begin errors++; $display("FAIL flush_skew_valid got %b want 0", skew_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got %b want 0", overflow); end
    checks++; if (skew !== 9'sd0) begin errors++; $display("FAIL flush_skew got %0d want 0", skew); end
    checks++; if (a_out !== 32'd1 || b_out !== 32'hD1) begin errors++; $display("FAIL flush_hold got a=%h b=%h want 1 d1", a_out, b_out); end
    idle();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", valid_out); end
    test_aligned_pair(32'h33, 32'h44);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h55, 1'b1, 32'h66, 1'b0);
    drive(1'b1, 32'h57, 1'b1, 32'h68, 1'b0);
    checks++; if (valid_out !== 1'b1 || a_out !== 32'h55) begin errors++; $display("FAIL ar_pre got v=%b a=%h want 1 55", valid_out, a_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || a_out !== 32'h0 || b_out !== 32'h0) begin errors++; $display("FAIL ar_outputs got v=%b a=%h b=%h want 0 0 0", valid_out, a_out, b_out); end
    checks++; if (skew !== 9'sd0 || skew_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL ar_flags got skew=%0d sv=%b ovf=%b want 0 0 0", skew, skew_valid, overflow); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ar_stale%0d got %b want 0", k, valid_out); end
    end
    test_aligned_pair(32'h11, 32'h22);
  endtask

  initial begin
    test_reset();
    test_aligned_pair(32'h11, 32'h22);
    test_lead_a();
    test_lead_b();
    test_overflow();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
